// File: rtl/morph_pkg.sv
// Shared constants for the binary morphology pipeline (row and column stages).
// Holds default image geometry and the EPS_CRS operation encoding.
// No logic; imported by every morphology file.
package morph_pkg;

    localparam int DEF_IMG_W = 640;
    localparam int DEF_IMG_H = 480;
    localparam int DEF_CNT_W = 12;

    // EPS_CRS encoding: dilation ORs the taps, erosion ANDs them.
    localparam logic MORPH_DILATE = 1'b1;
    localparam logic MORPH_ERODE  = 1'b0;

endpackage

// File: rtl/morph_col_if.sv
// Pixel stream bundle between the row stage, the column stage and the SDRAM writer.
// Combinational wiring only, no latency.
// No backpressure: the stream is pushed every pixel clock with din_val.
interface morph_col_if;
    import morph_pkg::*;

    logic       EPS_CRS;
    logic       cam_href;
    logic       cam_vsync;
    logic       din_val;
    logic       din;
    logic       morph_col_wr_en;
    logic       dout_1b;
    logic [7:0] dout_8b;
    logic       cam_href_r;
    logic       cam_vsync_r;

    // Upstream side: drives the pixel stream, receives the result.
    modport master (
        output EPS_CRS, cam_href, cam_vsync, din_val, din,
        input  morph_col_wr_en, dout_1b, dout_8b, cam_href_r, cam_vsync_r
    );

    // Column stage side.
    modport slave (
        input  EPS_CRS, cam_href, cam_vsync, din_val, din,
        output morph_col_wr_en, dout_1b, dout_8b, cam_href_r, cam_vsync_r
    );
endinterface

// File: rtl/morph_linebuf.sv
// One line of 1-bit pixel storage, single port, read-before-write.
// Read is combinational; a write lands on the next rising edge.
// No backpressure: accepts a write every cycle we is high.
module morph_linebuf #(
    parameter int DEPTH = 640,
    parameter int AW    = 10
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] addr,
    input  logic          wdat,
    output logic          rdat
);
    logic mem_q [DEPTH];

    // Old contents are visible on rdat during the write cycle, so chaining
    // two buffers shifts a column down by one line per write.
    assign rdat = mem_q[addr];

    // Storage write; contents need no reset because the border gate hides them.
    always_ff @(posedge clk) begin
        if (we) begin
            mem_q[addr] <= wdat;
        end
    end
endmodule

// File: rtl/morph_col.sv
// Vertical 3-tap binary dilation/erosion over the current and two previous lines.
// Latency: 1 clock from din_val to morph_col_wr_en/dout; syncs delayed to match.
// No backpressure: every din_val produces a write-enable one clock later.
module morph_col
    import morph_pkg::*;
#(
    parameter int IMG_W = DEF_IMG_W,
    parameter int IMG_H = DEF_IMG_H,
    parameter int CNT_W = DEF_CNT_W
) (
    input  logic        module_clk,
    input  logic        module_rst,
    morph_col_if.slave  bus
);
    localparam int               AW    = (IMG_W > 1) ? $clog2(IMG_W) : 1;
    localparam logic [CNT_W-1:0] X_LIM = CNT_W'(IMG_W);
    localparam logic [CNT_W-1:0] Y_LIM = CNT_W'(IMG_H - 1);
    localparam logic [CNT_W-1:0] Y_MIN = CNT_W'(2);

    logic             href_q,  href_d;
    logic             vsync_q, vsync_d;
    logic [CNT_W-1:0] x_cnt_q, x_cnt_d;
    logic [CNT_W-1:0] y_cnt_q, y_cnt_d;
    logic             wr_en_q, wr_en_d;
    logic             dout_q,  dout_d;

    logic             href_rise, href_fall, vsync_rise;
    logic             in_range;
    logic             lb_we;
    logic [AW-1:0]    lb_addr;
    logic             tap_top, tap_mid, tap_bot;
    logic             res;

    assign href_rise  =  bus.cam_href  & ~href_q;
    assign href_fall  = ~bus.cam_href  &  href_q;
    assign vsync_rise =  bus.cam_vsync & ~vsync_q;
    assign in_range   = (x_cnt_q < X_LIM);
    assign lb_we      = bus.din_val & in_range;
    assign lb_addr    = x_cnt_q[AW-1:0];
    assign tap_bot    = bus.din;

    // lb0 holds line y-1, lb1 holds line y-2; lb1 takes lb0's old value.
    morph_linebuf #(.DEPTH(IMG_W), .AW(AW)) u_lb0 (
        .clk  (module_clk),
        .we   (lb_we),
        .addr (lb_addr),
        .wdat (bus.din),
        .rdat (tap_mid)
    );

    morph_linebuf #(.DEPTH(IMG_W), .AW(AW)) u_lb1 (
        .clk  (module_clk),
        .we   (lb_we),
        .addr (lb_addr),
        .wdat (tap_mid),
        .rdat (tap_top)
    );

    // Tap combine with border gating: top two lines and overflow columns are 0.
    always_comb begin
        res = 1'b0;
        if (bus.EPS_CRS == MORPH_DILATE) begin
            res = tap_top | tap_mid | tap_bot;
        end else begin
            res = tap_top & tap_mid & tap_bot;
        end
        if ((y_cnt_q < Y_MIN) || !in_range) begin
            res = 1'b0;
        end
    end

    // Next-state for counters, sync registers and the output pipeline stage.
    always_comb begin
        href_d  = bus.cam_href;
        vsync_d = bus.cam_vsync;

        x_cnt_d = x_cnt_q;
        if (vsync_rise || href_rise) begin
            x_cnt_d = '0;
        end else if (bus.din_val && in_range) begin
            x_cnt_d = x_cnt_q + 1'b1;
        end

        // Frame start overrides a line end landing on the same cycle.
        y_cnt_d = y_cnt_q;
        if (vsync_rise) begin
            y_cnt_d = '0;
        end else if (href_fall && (y_cnt_q < Y_LIM)) begin
            y_cnt_d = y_cnt_q + 1'b1;
        end

        wr_en_d = bus.din_val;
        dout_d  = bus.din_val & res;
    end

    // State and output registers; reset clears everything except line storage.
    always_ff @(posedge module_clk or posedge module_rst) begin
        if (module_rst) begin
            href_q  <= 1'b0;
            vsync_q <= 1'b0;
            x_cnt_q <= '0;
            y_cnt_q <= '0;
            wr_en_q <= 1'b0;
            dout_q  <= 1'b0;
        end else begin
            href_q  <= href_d;
            vsync_q <= vsync_d;
            x_cnt_q <= x_cnt_d;
            y_cnt_q <= y_cnt_d;
            wr_en_q <= wr_en_d;
            dout_q  <= dout_d;
        end
    end

    // The sync edge registers are already the one-clock-delayed syncs.
    assign bus.morph_col_wr_en = wr_en_q;
    assign bus.dout_1b         = dout_q;
    assign bus.dout_8b         = {8{dout_q}};
    assign bus.cam_href_r      = href_q;
    assign bus.cam_vsync_r     = vsync_q;
endmodule

// File: tb/tb_morph_col.sv
// Directed bench for morph_col with an 8x4 image geometry.
// Inputs change 1 time unit after the rising edge; outputs are checked there too.
// Each pixel's result is checked one clock after it is presented.
module tb_morph_col;
    import morph_pkg::*;

    logic module_clk;
    logic module_rst;
    int   nchk;
    int   nfail;

    morph_col_if bus ();

    morph_col #(.IMG_W(8), .IMG_H(4), .CNT_W(12)) dut (
        .module_clk (module_clk),
        .module_rst (module_rst),
        .bus        (bus.slave)
    );

    initial module_clk = 1'b0;
    always #5 module_clk = ~module_clk;

    task automatic chk(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        nchk++;
        assert (obs === exp) else begin
            nfail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge module_clk);
        #1;
    endtask

    task automatic chk_idle(input string tag);
        chk({tag, "_wr_en"}, {7'd0, bus.morph_col_wr_en}, 8'd0);
        chk({tag, "_d1"},    {7'd0, bus.dout_1b},         8'd0);
        chk({tag, "_d8"},    bus.dout_8b,                 8'd0);
    endtask

    // Present one pixel, then check its result one clock later.
    task automatic pixel(input logic d, input logic e);
        bus.din_val = 1'b1;
        bus.din     = d;
        step();
        chk("px_wr_en",  {7'd0, bus.morph_col_wr_en}, 8'd1);
        chk("px_d1",     {7'd0, bus.dout_1b},         {7'd0, e});
        chk("px_d8",     bus.dout_8b,                 e ? 8'd255 : 8'd0);
        chk("px_href_r", {7'd0, bus.cam_href_r},      8'd1);
    endtask

    // One line: href up, n pixels, a trailing idle clock, then href down
    // (optionally with a vsync rise on the very same clock).
    task automatic line(input int n, input logic [15:0] bits,
                        input logic [15:0] expb, input logic vs_end);
        bus.cam_href = 1'b1;
        step();
        for (int i = 0; i < n; i++) begin
            pixel(bits[i], expb[i]);
        end
        bus.din_val = 1'b0;
        bus.din     = 1'b0;
        step();
        chk_idle("line_tail");
        bus.cam_href = 1'b0;
        if (vs_end) bus.cam_vsync = 1'b1;
        step();
        chk("href_r_low", {7'd0, bus.cam_href_r}, 8'd0);
        if (vs_end) begin
            chk("vsync_r_coinc", {7'd0, bus.cam_vsync_r}, 8'd1);
            bus.cam_vsync = 1'b0;
            step();
        end
        step();
    endtask

    task automatic frame_start();
        bus.cam_vsync = 1'b1;
        step();
        chk("vsync_r_hi", {7'd0, bus.cam_vsync_r}, 8'd1);
        bus.cam_vsync = 1'b0;
        step();
        chk("vsync_r_lo", {7'd0, bus.cam_vsync_r}, 8'd0);
        step();
    endtask

    initial begin
        nchk  = 0;
        nfail = 0;
        module_rst    = 1'b1;
        bus.EPS_CRS   = MORPH_ERODE;
        bus.cam_href  = 1'b0;
        bus.cam_vsync = 1'b0;
        bus.din_val   = 1'b0;
        bus.din       = 1'b0;
        repeat (2) step();
        chk_idle("reset");
        chk("reset_href_r",  {7'd0, bus.cam_href_r},  8'd0);
        chk("reset_vsync_r", {7'd0, bus.cam_vsync_r}, 8'd0);
        module_rst = 1'b0;
        step();

        // All-ones erosion: first two lines gated, then solid.
        frame_start();
        line(8, 16'h00FF, 16'h0000, 1'b0);
        line(8, 16'h00FF, 16'h0000, 1'b0);
        line(8, 16'h00FF, 16'h00FF, 1'b0);
        line(8, 16'h00FF, 16'h00FF, 1'b0);

        // Isolated pixel at line 2, x 3, dilation: appears on three outputs.
        bus.EPS_CRS = MORPH_DILATE;
        frame_start();
        line(8, 16'h0000, 16'h0000, 1'b0);
        line(8, 16'h0000, 16'h0000, 1'b0);
        line(8, 16'h0008, 16'h0008, 1'b0);
        line(8, 16'h0000, 16'h0008, 1'b0);
        line(8, 16'h0000, 16'h0008, 1'b0);
        line(8, 16'h0000, 16'h0000, 1'b0);

        // Same frame with erosion: the pixel vanishes everywhere.
        bus.EPS_CRS = MORPH_ERODE;
        frame_start();
        line(8, 16'h0000, 16'h0000, 1'b0);
        line(8, 16'h0000, 16'h0000, 1'b0);
        line(8, 16'h0008, 16'h0000, 1'b0);
        line(8, 16'h0000, 16'h0000, 1'b0);
        line(8, 16'h0000, 16'h0000, 1'b0);
        line(8, 16'h0000, 16'h0000, 1'b0);

        // Overlong line: columns 8 and 9 are written as 0; next line is clean.
        bus.EPS_CRS = MORPH_DILATE;
        frame_start();
        line(8,  16'h00FF, 16'h0000, 1'b0);
        line(8,  16'h00FF, 16'h0000, 1'b0);
        line(10, 16'h03FF, 16'h00FF, 1'b0);
        line(8,  16'h00FF, 16'h00FF, 1'b0);

        // Reset for three clocks in the middle of line 3.
        bus.EPS_CRS = MORPH_ERODE;
        frame_start();
        line(8, 16'h00FF, 16'h0000, 1'b0);
        line(8, 16'h00FF, 16'h0000, 1'b0);
        line(8, 16'h00FF, 16'h00FF, 1'b0);
        bus.cam_href = 1'b1;
        step();
        for (int i = 0; i < 3; i++) pixel(1'b1, 1'b1);
        bus.din_val = 1'b1;
        bus.din     = 1'b1;
        module_rst  = 1'b1;
        #1;
        chk_idle("rst_async");
        for (int i = 0; i < 3; i++) begin
            step();
            chk_idle("rst_hold");
            chk("rst_href_r", {7'd0, bus.cam_href_r}, 8'd0);
        end
        module_rst = 1'b0;
        for (int i = 3; i < 8; i++) pixel(1'b1, 1'b0);
        bus.din_val  = 1'b0;
        bus.din      = 1'b0;
        step();
        chk_idle("rst_tail");
        bus.cam_href = 1'b0;
        repeat (2) step();
        frame_start();
        line(8, 16'h00FF, 16'h0000, 1'b0);
        line(8, 16'h00FF, 16'h0000, 1'b0);
        line(8, 16'h00FF, 16'h00FF, 1'b0);

        // vsync rise on the same clock as href fall: the line count must
        // restart at 0, so the next two lines are gated again.
        line(8, 16'h00FF, 16'h00FF, 1'b1);
        line(8, 16'h00FF, 16'h0000, 1'b0);
        line(8, 16'h00FF, 16'h0000, 1'b0);
        line(8, 16'h00FF, 16'h00FF, 1'b0);

        $display("End of test - %0d assertions evaluated, %0d failures", nchk, nfail);
        $finish;
    end
endmodule
